// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencer for the 8-bit accumulator core.
// Takes branch offset/sign, soft reset and halt requests from execute and produces
// the instruction-memory address every cycle along with run/halt status.
// Optional feature: define INSTR_COUNT_EN to add the saturating InstrCount output.
module pc_fetch_ctrl #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic [7:0]      bOFFSET,
  input  logic            bSIGN,
  input  logic            SoftReset,
  input  logic            HaltReq,
  output logic [PC_W-1:0] PC,
  output logic            FetchValid,
  output logic            Running,
`ifdef INSTR_COUNT_EN
  output logic [15:0]     InstrCount,
`endif
  output logic            Halt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] offset_ext;

  // The size cast zero-extends for wide PCs and keeps only the low bits for narrow ones.
  assign offset_ext = PC_W'(bOFFSET);

  // State and PC registers; reset wins over everything, including a stall.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= START_ADDR;
    end else begin
      state <= state_next;
      PC    <= pc_next;
    end
  end

  // Next-state and next-PC selection; RUN rules are checked in priority order.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    unique case (state)
      IDLE, HALTED: begin
        if (Start) begin
          pc_next    = START_ADDR;
          state_next = RUN;
        end
      end
      RUN: begin
        if (Stall) begin
          pc_next = PC;
        end else if (SoftReset && HaltReq) begin
          state_next = HALTED;
        end else if (SoftReset) begin
          pc_next = START_ADDR;
        end else if (BranchEn) begin
          pc_next = bSIGN ? (PC - offset_ext) : (PC + offset_ext);
        end else begin
          pc_next = PC + PC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_ADDR;
      end
    endcase
  end

  // Status flags decode the registered state only, so no input reaches them combinationally.
  assign Running    = (state == RUN);
  assign FetchValid = (state == RUN);
  assign Halt       = (state == HALTED);

`ifdef INSTR_COUNT_EN
  logic [15:0] count_next;

  // Retired-instruction count: unstalled RUN cycles, cleared by a launching Start, saturating.
  always_comb begin
    count_next = InstrCount;
    if (state != RUN && Start) begin
      count_next = '0;
    end else if (state == RUN && !Stall && InstrCount != 16'hFFFF) begin
      count_next = InstrCount + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      InstrCount <= '0;
    end else begin
      InstrCount <= count_next;
    end
  end
`endif

endmodule
